opcode_injector: RTL and testbench
==================================

// Module: opcode_injector
// PURPOSE
// - Drives a JP nn sequence onto the Z80 data bus on the NABU side. It is the bus-driving counterpart of the M1 opcode snooper.
// - On a trap request, it waits for the first M1 fetch that starts a new instruction (new_isr=1). It then substitutes the bytes C3, lo, hi.
// - The CPU therefore vectors to trap_addr. Memory is inhibited for every injected byte.
// - Z80 strobes are asynchronous. They are synchronised into clk, so clk must run at 8x the Z80 clock or faster.
// PARAMETERS
// - SYNC_STAGES  2      flop stages on m1_n/mreq_n/rd_n/wr_n (range 2..3)
// - JP_OPCODE    8'hC3  opcode byte driven in the M1 slot
// - CALL_OPCODE  8'hCD  opcode used when INJECT_CALL_EN is defined
// PORTS
// - clk           in   1   system clock; only clock domain
// - rst           in   1   synchronous, active-high reset
// - m1_n          in   1   Z80 M1, async
// - mreq_n        in   1   Z80 MREQ, async
// - rd_n          in   1   Z80 RD, async
// - wr_n          in   1   Z80 WR, async (used only with INJECT_CALL_EN)
// - data_in       in   8   Z80 data bus, sampled during writes
// - new_isr       in   1   from snooper: next M1 begins a new instruction
// - trap_req      in   1   level; a request while busy is ignored
// - trap_addr     in   16  vector; latched when trap_req is accepted
// - data_out      out  8   byte to drive
// - data_oe       out  1   bus driver enable
// - mem_inhibit   out  1   blocks ROM/RAM decode; equals data_oe
// - busy          out  1   high in any state other than IDLE
// - done          out  1   1-clk pulse when the sequence completes
// - err           out  1   1-clk pulse when a sequence aborts
// - ret_addr      out  16  pushed return address (INJECT_CALL_EN only, else 0)
// BEHAVIOUR
// - Reset: state=IDLE; data_out=0, data_oe=0, busy=0, done=0, err=0, ret_addr=0; synchroniser flops to 1.
// - Synchronised terms:
//   - rd_cyc = !mreq_s & !rd_s
//   - wr_cyc = !mreq_s & !wr_s
//   - rise/fall are edges of the synchronised signals.
// - IDLE: trap_req=1 -> latch trap_addr, go to ARMED.
// - ARMED: on rd_cyc rising with m1_s=0, decide on new_isr sampled at that edge.
//   - new_isr=1 -> go to OP.
//   - new_isr=0 -> stay in ARMED.
//   - A fetch already in progress when ARMED is entered is not used; the next rising edge is required.
// - OP: data_out=opcode; data_oe=rd_cyc (combinational on synchronised signals). When rd_cyc falls, go to LO.
// - LO: wait for rd_cyc rising with m1_s=1.
//   - Drive trap_addr[7:0] while rd_cyc is high.
//   - When rd_cyc falls, go to HI.
// - HI: same as LO but drives trap_addr[15:8].
//   - When rd_cyc falls: done pulse and go to IDLE, or go to PUSH if INJECT_CALL_EN.
// - Refresh cycle after M1 (mreq low, rd high) is ignored in every state.
// - IORQ/INTA M1 cycles have no mreq, so they never match.
// - An M1 read rising in LO, HI or PUSH -> err pulse, data_oe=0, go to IDLE. trap_req must then be re-asserted.
// - data_oe never asserts outside an active rd_cyc. Latency from a Z80 strobe edge to data_oe is SYNC_STAGES+0 clk.
// - rst while data_oe=1 drops data_oe on the next clk; the sequence is abandoned with no done and no err.
// CONFIGURATION
// - INJECT_CALL_EN defined:
//   - The opcode is CALL_OPCODE.
//   - After HI, the state is PUSH. It counts two wr_cyc rising edges with m1_s=1.
//   - Data on the 1st write -> ret_addr[15:8]; data on the 2nd write -> ret_addr[7:0], sampled at wr_cyc fall.
//   - done pulses after the 2nd write. busy stays high through PUSH.
// - INJECT_CALL_EN undefined:
//   - JP_OPCODE is used and the PUSH state is absent.
//   - wr_n and data_in are unused; ret_addr stays 0.
// TESTING
// - Reset: hold rst 3 clk while trap_req=1 -> all outputs 0; state IDLE after release.
// - Basic JP: trap_addr=16'h1234, new_isr=1, then M1 read + 2 reads -> bus sees C3,34,12; done once; data_oe only inside rd windows.
// - Prefix: first M1 with new_isr=0 (opcode DD) -> no injection; next M1 with new_isr=1 -> C3 injected.
// - Refresh/INTA: M1+refresh and an M1 with iorq only between the injected bytes -> no state change, data_oe=0.
// - Abort: after C3, an M1 read arrives instead of an operand read -> err pulse; data_oe=0; busy=0.
// - CALL (INJECT_CALL_EN): trap_addr=16'h0066, CPU pushes 0x80 then 0x1F -> bus sees CD,66,00; ret_addr=16'h801F; done after 2nd write.

Source files
------------

// File: rtl/opcode_injector.sv
// Drives JP nn (CALL nn when INJECT_CALL_EN is defined) onto the Z80 data bus at the first
// new-instruction M1 fetch after a trap request, inhibiting memory for each injected byte.
module opcode_injector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  JP_OPCODE   = 8'hC3,
    parameter logic [7:0]  CALL_OPCODE = 8'hCD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m1_n_i,
    input  logic        mreq_n_i,
    input  logic        rd_n_i,
    input  logic        wr_n_i,
    input  logic [7:0]  data_in_i,
    input  logic        new_isr_i,
    input  logic        trap_req_i,
    input  logic [15:0] trap_addr_i,
    output logic [7:0]  data_out_o,
    output logic        data_oe_o,
    output logic        mem_inhibit_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] ret_addr_o
);

`ifdef INJECT_CALL_EN
    localparam logic [7:0] OPCODE = CALL_OPCODE;
`else
    localparam logic [7:0] OPCODE = JP_OPCODE;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        OP    = 3'd2,
        LO    = 3'd3,
        HI    = 3'd4
`ifdef INJECT_CALL_EN
        ,PUSH = 3'd5
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  data_out_c;
    logic        data_oe_c;

    // Strobe synchronisers; idle-high reset value keeps every cycle term inactive
    logic [SYNC_STAGES-1:0] m1_sq, mreq_sq, rd_sq;
    logic m1_s, mreq_s, rd_s;
    logic rd_cyc, rd_cyc_q, rd_rise, rd_fall, m1_rd_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m1_sq    <= '1;
            mreq_sq  <= '1;
            rd_sq    <= '1;
            rd_cyc_q <= 1'b0;
        end else begin
            m1_sq    <= {m1_sq[SYNC_STAGES-2:0], m1_n_i};
            mreq_sq  <= {mreq_sq[SYNC_STAGES-2:0], mreq_n_i};
            rd_sq    <= {rd_sq[SYNC_STAGES-2:0], rd_n_i};
            rd_cyc_q <= rd_cyc;
        end
    end

    assign m1_s       = m1_sq[SYNC_STAGES-1];
    assign mreq_s     = mreq_sq[SYNC_STAGES-1];
    assign rd_s       = rd_sq[SYNC_STAGES-1];
    assign rd_cyc     = !mreq_s && !rd_s;
    assign rd_rise    = rd_cyc && !rd_cyc_q;
    assign rd_fall    = !rd_cyc && rd_cyc_q;
    assign m1_rd_rise = rd_rise && !m1_s;

`ifdef INJECT_CALL_EN
    logic [SYNC_STAGES-1:0] wr_sq;
    logic        wr_cyc, wr_cyc_q, wr_fall;
    logic        wr_idx_q, wr_idx_d;
    logic [15:0] ret_addr_q, ret_addr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sq      <= '1;
            wr_cyc_q   <= 1'b0;
            wr_idx_q   <= 1'b0;
            ret_addr_q <= 16'h0000;
        end else begin
            wr_sq      <= {wr_sq[SYNC_STAGES-2:0], wr_n_i};
            wr_cyc_q   <= wr_cyc;
            wr_idx_q   <= wr_idx_d;
            ret_addr_q <= ret_addr_d;
        end
    end

    assign wr_cyc     = !mreq_s && !wr_sq[SYNC_STAGES-1];
    assign wr_fall    = !wr_cyc && wr_cyc_q;
    assign ret_addr_o = ret_addr_q;
`else
    logic unused_c;
    assign unused_c   = ^{wr_n_i, data_in_i};
    assign ret_addr_o = 16'h0000;
`endif

    logic unused_param_c;
    assign unused_param_c = ^{JP_OPCODE, CALL_OPCODE};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Sequence control; the bus driver follows the synchronised read window with no extra delay
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        data_out_c = 8'h00;
        data_oe_c  = 1'b0;
`ifdef INJECT_CALL_EN
        wr_idx_d   = wr_idx_q;
        ret_addr_d = ret_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (trap_req_i) begin
                    addr_d  = trap_addr_i;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                data_out_c = OPCODE;
                if (m1_rd_rise && new_isr_i) begin
                    data_oe_c = 1'b1;
                    state_d   = OP;
                end
            end
            OP: begin
                data_out_c = OPCODE;
                data_oe_c  = rd_cyc;
                if (rd_fall) state_d = LO;
            end
            LO: begin
                data_out_c = addr_q[7:0];
                data_oe_c  = rd_cyc && m1_s;
                if (m1_rd_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rd_fall) begin
                    state_d = HI;
                end
            end
            HI: begin
                data_out_c = addr_q[15:8];
                data_oe_c  = rd_cyc && m1_s;
                if (m1_rd_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rd_fall) begin
`ifdef INJECT_CALL_EN
                    wr_idx_d = 1'b0;
                    state_d  = PUSH;
`else
                    done_d   = 1'b1;
                    state_d  = IDLE;
`endif
                end
            end
`ifdef INJECT_CALL_EN
            // CPU pushes the return address high byte first
            PUSH: begin
                if (m1_rd_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wr_fall && m1_s) begin
                    if (!wr_idx_q) begin
                        ret_addr_d[15:8] = data_in_i;
                        wr_idx_d         = 1'b1;
                    end else begin
                        ret_addr_d[7:0] = data_in_i;
                        done_d          = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign data_out_o    = data_out_c;
    assign data_oe_o     = data_oe_c;
    assign mem_inhibit_o = data_oe_c;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_opcode_injector.sv
// Bench for opcode_injector: transaction-level model of the injected byte stream, checked every clock.
module tb_opcode_injector;

    localparam int unsigned SS = 2;
`ifdef INJECT_CALL_EN
    localparam logic [7:0] OPC = 8'hCD;
`else
    localparam logic [7:0] OPC = 8'hC3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m1_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        new_isr = 1'b0;
    logic        trap_req = 1'b0;
    logic [15:0] trap_addr = 16'h0000;
    logic [7:0]  data_out;
    logic        data_oe, mem_inhibit, busy, done, err;
    logic [15:0] ret_addr;

    always #5 clk = ~clk;

    opcode_injector #(.SYNC_STAGES(SS)) dut (
        .clk_i(clk), .rst_i(rst), .m1_n_i(m1_n), .mreq_n_i(mreq_n), .rd_n_i(rd_n),
        .wr_n_i(wr_n), .data_in_i(data_in), .new_isr_i(new_isr), .trap_req_i(trap_req),
        .trap_addr_i(trap_addr), .data_out_o(data_out), .data_oe_o(data_oe),
        .mem_inhibit_o(mem_inhibit), .busy_o(busy), .done_o(done), .err_o(err),
        .ret_addr_o(ret_addr)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 armed, 2 expect low operand, 3 expect high operand, 4 expect pushes
    int          m_stage = 0;
    logic [15:0] m_addr = 16'h0000;
    logic        m_inj = 1'b0;
    logic [7:0]  m_byte = 8'h00;
    logic        m_wr = 1'b0;
    logic [15:0] m_ret = 16'h0000;
    int          exp_done = 0, exp_err = 0;
    int          got_done = 0, got_err = 0;
    logic [7:0]  seen[$];

    // Expected driver state lags the raw strobes by the synchroniser depth
    logic [SS-1:0] p_oe = '0;
    logic [7:0]    p_byte[SS];
    logic          prev_oe = 1'b0;
    logic          rst_seen;

    initial begin
        for (int i = 0; i < SS; i++) p_byte[i] = 8'h00;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            if (rst) begin
                p_oe = '0;
            end else begin
                for (int i = SS - 1; i > 0; i--) begin
                    p_oe[i]   = p_oe[i-1];
                    p_byte[i] = p_byte[i-1];
                end
                p_oe[0]   = !mreq_n && !rd_n && m_inj;
                p_byte[0] = m_byte;
            end
            #1;
            if (done) got_done++;
            if (err) got_err++;
            check("data_oe", {31'd0, data_oe}, {31'd0, p_oe[SS-1]});
            check("mem_inhibit", {31'd0, mem_inhibit}, {31'd0, p_oe[SS-1]});
            if (p_oe[SS-1]) check("data_out", {24'd0, data_out}, {24'd0, p_byte[SS-1]});
            if (rst_seen) begin
                check("rst_data_out", {24'd0, data_out}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_err", {31'd0, err}, 32'd0);
                check("rst_ret_addr", {16'd0, ret_addr}, 32'd0);
            end
            if (data_oe && !prev_oe) seen.push_back(data_out);
            prev_oe = data_oe;
        end
    end

    task automatic trap(input logic [15:0] a);
        @(negedge clk);
        trap_addr = a;
        trap_req  = 1'b1;
        if (m_stage == 0) begin
            m_stage = 1;
            m_addr  = a;
        end
        @(negedge clk);
        trap_req = 1'b0;
    endtask

    task automatic rd_txn(input bit m1, input bit nisr);
        @(negedge clk);
        new_isr = nisr;
        m_inj   = 1'b0;
        m_byte  = 8'h00;
        case (m_stage)
            1: if (m1 && nisr) begin
                m_inj = 1'b1; m_byte = OPC; m_stage = 2;
            end
            2, 3: if (m1) begin
                exp_err++; m_stage = 0;
            end else begin
                m_inj  = 1'b1;
                m_byte = (m_stage == 2) ? m_addr[7:0] : m_addr[15:8];
                if (m_stage == 2) m_stage = 3;
                else begin
`ifdef INJECT_CALL_EN
                    m_stage = 4; m_wr = 1'b0;
`else
                    m_stage = 0; exp_done++;
`endif
                end
            end
            4: if (m1) begin
                exp_err++; m_stage = 0;
            end
            default: ;
        endcase
        m1_n = !m1; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (4) @(negedge clk);
        rd_n = 1'b1; mreq_n = 1'b1; m1_n = 1'b1;
        if (m1) begin
            @(negedge clk);
            mreq_n = 1'b0;
            repeat (3) @(negedge clk);
            mreq_n = 1'b1;
        end
        repeat (4) @(negedge clk);
        new_isr = 1'b0;
    endtask

    task automatic inta_m1();
        @(negedge clk);
        m1_n = 1'b0;
        repeat (4) @(negedge clk);
        m1_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic refresh();
        @(negedge clk);
        mreq_n = 1'b0;
        repeat (3) @(negedge clk);
        mreq_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_txn(input logic [7:0] b);
        @(negedge clk);
        if (m_stage == 4) begin
            if (!m_wr) begin
                m_ret[15:8] = b; m_wr = 1'b1;
            end else begin
                m_ret[7:0] = b; m_stage = 0; exp_done++;
            end
        end
        data_in = b; mreq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        wr_n = 1'b1; mreq_n = 1'b1;
        repeat (4) @(negedge clk);
        data_in = 8'h00;
    endtask

    task automatic check_seen(input string name, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b[3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        check({name, "_count"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            check({name, "_byte"}, {24'd0, seen[i]}, {24'd0, b[i]});
        seen.delete();
    endtask

    task automatic check_counts(input string name);
        check({name, "_done"}, got_done, exp_done);
        check({name, "_err"}, got_err, exp_err);
        check({name, "_busy"}, {31'd0, busy}, {31'd0, (m_stage != 0)});
    endtask

    initial begin
        // Reset held with a pending trap request
        trap_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        trap_req = 1'b0;
        @(posedge clk); #1;
        check("busy_after_rst", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Basic sequence
        trap(16'h1234);
        rd_txn(1, 1);
        rd_txn(0, 0);
        rd_txn(0, 0);
`ifndef INJECT_CALL_EN
        check_seen("basic", 3, 8'hC3, 8'h34, 8'h12);
        check("basic_done_lit", got_done, 1);
`else
        seen.delete();
        repeat (3) wr_txn(8'h00);
`endif
        check_counts("basic");

        // Prefix fetch skipped; refresh and INTA M1 between operands ignored
        trap(16'hABCD);
        rd_txn(1, 0);
        rd_txn(1, 1);
        check("prefix_busy_lit", {31'd0, busy}, 32'd1);
        inta_m1();
        refresh();
        rd_txn(0, 0);
        inta_m1();
        rd_txn(0, 0);
`ifdef INJECT_CALL_EN
        wr_txn(8'h12);
        wr_txn(8'h34);
`endif
        check_seen("prefix", 3, OPC, 8'hCD, 8'hAB);
        check_counts("prefix");

        // Abort: M1 read where an operand was expected
        trap(16'h5555);
        rd_txn(1, 1);
        rd_txn(1, 1);
        check_seen("abort", 1, OPC, 8'h00, 8'h00);
        check("abort_err_lit", got_err, 1);
        check_counts("abort");

        // Trap accepted mid-fetch: that fetch is not used, the next one is
        fork
            rd_txn(1, 1);
            begin repeat (3) @(negedge clk); trap(16'h0F0F); end
        join
        check_seen("midfetch_none", 0, 8'h00, 8'h00, 8'h00);
        rd_txn(1, 1);
        rd_txn(0, 0);
        rd_txn(0, 0);
`ifdef INJECT_CALL_EN
        wr_txn(8'h01);
        wr_txn(8'h02);
`endif
        check_seen("midfetch", 3, OPC, 8'h0F, 8'h0F);
        check_counts("midfetch");

        // Reset while driving the opcode abandons the sequence silently
        trap(16'h7777);
        fork
            rd_txn(1, 1);
            begin
                repeat (4) @(negedge clk);
                rst = 1'b1; m_stage = 0; m_inj = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        seen.delete();
        rd_txn(0, 0);
        check_seen("post_rst", 0, 8'h00, 8'h00, 8'h00);
        check_counts("post_rst");

`ifdef INJECT_CALL_EN
        // CALL with return address push
        trap(16'h0066);
        rd_txn(1, 1);
        rd_txn(0, 0);
        rd_txn(0, 0);
        check("call_busy_push", {31'd0, busy}, 32'd1);
        wr_txn(8'h80);
        wr_txn(8'h1F);
        check_seen("call", 3, 8'hCD, 8'h66, 8'h00);
        check("call_ret_lit", {16'd0, ret_addr}, 32'h801F);
        check("call_ret_model", {16'd0, ret_addr}, {16'd0, m_ret});
        check_counts("call");
`else
        check("ret_addr_zero", {16'd0, ret_addr}, 32'd0);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
